// File: rtl/des_input_sequencer.sv
// des_input_sequencer: assembles two 32-bit stream words into a 64-bit operand,
// issues it to the 3DES core, and buffers one block result behind a valid/ready port.
module des_input_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_mode,
  input  logic [31:0] in_data,
  output logic [2:0]  des_mode,
  output logic        des_enable,
  output logic [63:0] des_data_in,
  input  logic        des_data_ready,
  input  logic [63:0] des_data_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        busy,
  output logic        err_mode,
  output logic        err_timeout
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_HALF, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic              alive_q;
  logic [2:0]        pmode_q, pmode_d;
  logic [31:0]       upper_q, upper_d;
  logic [2:0]        mode_q, mode_d;
  logic [63:0]       din_q, din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              rvalid_q, rvalid_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              emode_q, emode_d;
  logic              eto_q, eto_d;

  function automatic logic is_illegal(input logic [2:0] m);
    return (m == 3'b101) || (m == 3'b110) || (m == 3'b111);
  endfunction

  function automatic logic is_key(input logic [2:0] m);
    return (m == 3'b010) || (m == 3'b011);
  endfunction

  function automatic logic is_block(input logic [2:0] m);
    return (m == 3'b000) || (m == 3'b001) || (m == 3'b100);
  endfunction

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and flag registers; cleared by reset so every output reads zero.
  // alive_q keeps in_ready low while reset is held.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      alive_q  <= 1'b0;
      pmode_q  <= '0;
      upper_q  <= '0;
      mode_q   <= '0;
      din_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      emode_q  <= 1'b0;
      eto_q    <= 1'b0;
    end else begin
      alive_q  <= 1'b1;
      pmode_q  <= pmode_d;
      upper_q  <= upper_d;
      mode_q   <= mode_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      emode_q  <= emode_d;
      eto_q    <= eto_d;
    end
  end

  // Next-state, handshake and capture logic.
  always_comb begin
    state_d    = state_q;
    pmode_d    = pmode_q;
    upper_d    = upper_q;
    mode_d     = mode_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    emode_d    = 1'b0;
    eto_d      = 1'b0;
    in_ready   = 1'b0;
    des_enable = 1'b0;
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    if (rvalid_q && res_ready) rvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A new block op must not overwrite an unconsumed result.
        in_ready = alive_q && !(rvalid_q && is_block(in_mode));
        if (in_valid && in_ready) begin
          if (is_illegal(in_mode)) begin
            emode_d = 1'b1;
          end else begin
            upper_d = in_data;
            pmode_d = in_mode;
            state_d = S_HALF;
          end
        end
      end
      S_HALF: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Core-facing operand only changes once both halves are present.
          din_d   = {upper_q, in_data};
          mode_d  = pmode_q;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        des_enable = 1'b1;
        cnt_d      = '0;
        state_d    = is_key(mode_q) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (des_data_ready) begin
          rdata_d  = des_data_out;
          rvalid_d = 1'b1;
          state_d  = S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
          eto_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign des_mode    = mode_q;
  assign des_data_in = din_q;
  assign res_valid   = rvalid_q;
  assign res_data    = rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign err_mode    = emode_q;
  assign err_timeout = eto_q;

endmodule
